// File: rtl/sha3_pkg.sv
// Shared SHA-3 types: Keccak lane/state, rate table, absorb FSM states.
package sha3_pkg;

  typedef logic [63:0]        lane_t;
  typedef lane_t [4:0][4:0]   state_t;

  // Widest rate (SHA3-224); the packer buffer is sized for it.
  localparam int MAX_RATE = 1152;

  // Rate in bits per TUSER digest-size code: 224, 256, 384, 512.
  localparam int RATE_BITS [4] = '{1152, 1088, 832, 576};

  typedef enum logic [1:0] {S_FILL, S_EMIT, S_PADBLK} absorb_st_t;

  // Number of stream words that fill one rate block.
  function automatic int rate_words(input logic [1:0] tuser, input int dw);
    return RATE_BITS[tuser] / dw;
  endfunction

endpackage

// File: rtl/sha_pad.sv
// SHA-3 pad10*1 with the 0x06 domain byte, applied to a flat rate vector.
// Used both for the partial final block and for the padding-only block.
module sha_pad
  import sha3_pkg::*;
(
  input  logic [MAX_RATE-1:0] flat_i,
  input  logic [7:0]          pad_pos_i,
  input  logic [7:0]          rate_bytes_i,
  output logic [MAX_RATE-1:0] flat_o
);

  // 0x06 at the first free byte, 0x80 OR'ed into the last rate byte;
  // the two merge into 0x86 when they land on the same byte.
  always_comb begin
    flat_o = flat_i;
    for (int b = 0; b < MAX_RATE/8; b++) begin
      if (8'(b) == pad_pos_i)
        flat_o[8*b +: 8] = 8'h06;
      if (8'(b) == rate_bytes_i - 8'd1)
        flat_o[8*b +: 8] = flat_o[8*b +: 8] | 8'h80;
    end
  end

endmodule

// File: rtl/sha_absorb.sv
// SHA-3 ingress packer: packs stream words into the rate part of a Keccak
// state, pads the final block and offers each block with valid/ready.
module sha_absorb
  import sha3_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_W      = 8
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [DATA_WIDTH-1:0] S_TDATA,
  input  logic                  S_TVALID,
  output logic                  S_TREADY,
  input  logic                  S_TLAST,
  input  logic [1:0]            S_TUSER,
  output state_t                Block,
  output logic                  Block_valid,
  input  logic                  Block_ready,
  output logic                  Block_last,
  output logic [1:0]            Block_mode
);

  localparam int BPW = DATA_WIDTH / 8;

  absorb_st_t          st_q, st_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [MAX_RATE-1:0] flat_q, flat_d, flat_wr, pad_in, pad_out;
  logic                last_q, last_d;
  logic                pend_q, pend_d;
  logic                arm_q, arm_d;      // next accepted beat starts a message
  logic                rdy_q;             // holds TREADY low through reset
  logic [1:0]          mode_q, mode_d, mode_eff;
  logic [7:0]          pad_pos, rate_bytes;
  int                  rw;

  // Mode in force for this beat: the live TUSER on a message's first beat.
  always_comb begin
    mode_eff   = arm_q ? S_TUSER : mode_q;
    rw         = rate_words(mode_eff, DATA_WIDTH);
    rate_bytes = 8'(RATE_BITS[mode_eff] / 8);
  end

  // Current beat merged into the block buffer at word slot cnt.
  always_comb begin
    flat_wr = flat_q;
    flat_wr[int'(cnt_q)*DATA_WIDTH +: DATA_WIDTH] = S_TDATA;
  end

  // Padder input: the merged final beat, or an empty block for S_PADBLK.
  always_comb begin
    if (st_q == S_PADBLK) begin
      pad_in  = '0;
      pad_pos = '0;
    end else begin
      pad_in  = flat_wr;
      pad_pos = 8'((int'(cnt_q) + 1) * BPW);
    end
  end

  sha_pad u_pad (
    .flat_i       (pad_in),
    .pad_pos_i    (pad_pos),
    .rate_bytes_i (rate_bytes),
    .flat_o       (pad_out)
  );

  // Next-state logic: fill, emit with handshake, padding-only block.
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    flat_d = flat_q;
    last_d = last_q;
    pend_d = pend_q;
    mode_d = mode_q;
    arm_d  = arm_q;
    unique case (st_q)
      S_FILL: begin
        if (S_TVALID) begin
          flat_d = flat_wr;
          if (arm_q) begin
            mode_d = S_TUSER;
            arm_d  = 1'b0;
          end
          if (S_TLAST && (int'(cnt_q) < rw - 1)) begin
            flat_d = pad_out;
            last_d = 1'b1;
            cnt_d  = '0;
            st_d   = S_EMIT;
          end else if (int'(cnt_q) == rw - 1) begin
            // Exactly full block; a final one defers its padding.
            last_d = 1'b0;
            pend_d = S_TLAST;
            cnt_d  = '0;
            st_d   = S_EMIT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_EMIT: begin
        if (Block_ready) begin
          flat_d = '0;
          if (pend_q) begin
            st_d = S_PADBLK;
          end else begin
            st_d = S_FILL;
            if (last_q) arm_d = 1'b1;
          end
        end
      end
      S_PADBLK: begin
        flat_d = pad_out;
        last_d = 1'b1;
        pend_d = 1'b0;
        st_d   = S_EMIT;
      end
      default: st_d = S_FILL;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      st_q   <= S_FILL;
      cnt_q  <= '0;
      flat_q <= '0;
      last_q <= 1'b0;
      pend_q <= 1'b0;
      mode_q <= 2'd0;
      arm_q  <= 1'b1;
      rdy_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      flat_q <= flat_d;
      last_q <= last_d;
      pend_q <= pend_d;
      mode_q <= mode_d;
      arm_q  <= arm_d;
      rdy_q  <= 1'b1;
    end
  end

  // Outputs: flat lane i appears at Block[i%5][i/5]; capacity lanes stay 0.
  always_comb begin
    S_TREADY    = rdy_q && (st_q == S_FILL);
    Block_valid = (st_q == S_EMIT);
    Block_last  = last_q;
    Block_mode  = mode_q;
    Block       = '0;
    for (int i = 0; i < MAX_RATE/64; i++)
      Block[i%5][i/5] = flat_q[64*i +: 64];
  end

endmodule

// File: tb/tb_sha_absorb.sv
// Bench for sha_absorb: one 16-bit and one 8-bit instance, random data,
// message-level reference model of SHA-3 block splitting and padding.
module tb_sha_absorb;
  import sha3_pkg::*;

  typedef struct { state_t blk; logic last; logic [1:0] mode; } rec_t;

  logic        clk = 0, rst = 1, sel = 0;
  logic        tvalid = 0, tlast = 0, bready = 0;
  logic [1:0]  tuser = 0;
  logic [63:0] tdata = 0;
  logic        tready16, bv16, bl16, tready8, bv8, bl8;
  logic [1:0]  bm16, bm8;
  state_t      blk16, blk8;
  logic        tready, bv, bl;
  logic [1:0]  bm;
  state_t      blk;

  int          tests = 0, fails = 0;
  int          rdy_mode = 0, stall_cnt = 0;
  int          rate_tab [4] = '{1152, 1088, 832, 576};
  logic [7:0]  mb [$];
  rec_t        actq [$], expq [$];
  state_t      prev_blk;
  logic        prev_last;
  bit          prev_offer = 0;

  always #5 clk = ~clk;

  sha_absorb #(.DATA_WIDTH(16), .CNT_W(8)) u16 (
    .ACLK(clk), .ARESET(rst), .S_TDATA(tdata[15:0]), .S_TVALID(tvalid & ~sel),
    .S_TREADY(tready16), .S_TLAST(tlast), .S_TUSER(tuser), .Block(blk16),
    .Block_valid(bv16), .Block_ready(bready & ~sel), .Block_last(bl16), .Block_mode(bm16));

  sha_absorb #(.DATA_WIDTH(8), .CNT_W(8)) u8 (
    .ACLK(clk), .ARESET(rst), .S_TDATA(tdata[7:0]), .S_TVALID(tvalid & sel),
    .S_TREADY(tready8), .S_TLAST(tlast), .S_TUSER(tuser), .Block(blk8),
    .Block_valid(bv8), .Block_ready(bready & sel), .Block_last(bl8), .Block_mode(bm8));

  assign tready = sel ? tready8 : tready16;
  assign bv     = sel ? bv8     : bv16;
  assign bl     = sel ? bl8     : bl16;
  assign bm     = sel ? bm8     : bm16;
  assign blk    = sel ? blk8    : blk16;

  function automatic int first_diff(input state_t a, input state_t b);
    for (int i = 0; i < 25; i++) if (a[i%5][i/5] !== b[i%5][i/5]) return i;
    return 0;
  endfunction

  // Block consumer: drives Block_ready, records handshakes, checks stability.
  always @(negedge clk) begin
    if (rst) begin
      bready = 0; prev_offer = 0; stall_cnt = 0;
    end else begin
      case (rdy_mode)
        0: bready = 1;
        1: bready = 1'($urandom_range(0, 1));
        2: bready = bv && (stall_cnt >= 5);
        default: bready = 0;
      endcase
      if (bv) begin
        tests++;
        if (tready !== 1'b0) begin
          fails++; $display("FAIL tready_during_offer: got %b want 0", tready);
        end
        if (prev_offer) begin
          tests++;
          if (blk !== prev_blk || bl !== prev_last) begin
            fails++; $display("FAIL offer_stable: lane%0d got %h want %h last got %b want %b",
              first_diff(blk, prev_blk), blk[first_diff(blk, prev_blk)%5][first_diff(blk, prev_blk)/5],
              prev_blk[first_diff(blk, prev_blk)%5][first_diff(blk, prev_blk)/5], bl, prev_last);
          end
        end
        if (bready) begin
          actq.push_back('{blk, bl, bm}); prev_offer = 0; stall_cnt = 0;
        end else begin
          prev_offer = 1; prev_blk = blk; prev_last = bl; stall_cnt++;
        end
      end else prev_offer = 0;
    end
  end

  // Sends one message on the selected instance; bytes collected in mb.
  task automatic send_msg(input int nw, input int mode, input int later, input longint pat,
                          input bit gaps, input bit with_last);
    int dw = sel ? 8 : 16;
    logic [63:0] w;
    bit ok;
    mb.delete();
    for (int i = 0; i < nw; i++) begin
      w = (pat < 0) ? {$urandom, $urandom} : 64'(pat);
      w = w & ((64'd1 << dw) - 64'd1);
      for (int b = 0; b < dw/8; b++) mb.push_back(w[8*b +: 8]);
      if (gaps && $urandom_range(0, 3) == 0) begin @(negedge clk); tvalid = 0; end
      ok = 0;
      for (int g = 0; g < 500 && !ok; g++) begin
        @(negedge clk);
        tdata = w; tvalid = 1; tlast = with_last && (i == nw - 1);
        tuser = (i == 0) ? 2'(mode) : (later < 0 ? 2'($urandom_range(0, 3)) : 2'(later));
        if (tready) begin @(posedge clk); ok = 1; end
      end
      if (!ok) begin
        tests++; fails++; $display("FAIL accept_timeout: word %0d not accepted", i);
        #1 tvalid = 0; tlast = 0;
        return;
      end
    end
    #1 tvalid = 0; tlast = 0;
  endtask

  // Reference: split message bytes into rate blocks, pad the tail.
  task automatic model_msg(input int mode);
    int r = rate_tab[mode] / 8;
    int pos = 0, n;
    logic [7:0] fl [200];
    rec_t rec;
    while (1) begin
      foreach (fl[j]) fl[j] = 8'h00;
      n = (mb.size() - pos < r) ? mb.size() - pos : r;
      for (int j = 0; j < n; j++) fl[j] = mb[pos + j];
      pos += n;
      rec.last = (n < r);
      if (n < r) begin fl[n] = 8'h06; fl[r-1] = fl[r-1] | 8'h80; end
      for (int i = 0; i < 25; i++)
        for (int b = 0; b < 8; b++) rec.blk[i%5][i/5][8*b +: 8] = fl[8*i + b];
      rec.mode = 2'(mode);
      expq.push_back(rec);
      if (n < r) break;
    end
  endtask

  task automatic test_reset();
    rst = 1; repeat (3) @(posedge clk); @(negedge clk);
    tests++; if (tready16 !== 0 || tready8 !== 0) begin fails++; $display("FAIL reset_tready: got %b/%b want 0", tready16, tready8); end
    tests++; if (bv16 !== 0 || bv8 !== 0) begin fails++; $display("FAIL reset_valid: got %b/%b want 0", bv16, bv8); end
    tests++; if (bl16 !== 0 || bl8 !== 0) begin fails++; $display("FAIL reset_last: got %b/%b want 0", bl16, bl8); end
    tests++; if (bm16 !== 0 || bm8 !== 0) begin fails++; $display("FAIL reset_mode: got %0d/%0d want 0", bm16, bm8); end
    tests++; if (blk16 !== '0 || blk8 !== '0) begin fails++; $display("FAIL reset_block: lane0 got %h want 0", blk16[0][0]); end
    rst = 0; @(posedge clk); @(negedge clk);
    tests++; if (tready16 !== 1) begin fails++; $display("FAIL reset_release_tready: got %b want 1", tready16); end
  endtask

  task automatic test_single();
    int k;
    sel = 0; rdy_mode = 0; actq.delete(); expq.delete();
    send_msg(1, 1, -1, 64'h6261, 0, 1);
    @(negedge clk);
    tests++; if (bv !== 1) begin fails++; $display("FAIL single_latency: valid got %b want 1", bv); end
    model_msg(1); repeat (20) @(negedge clk);
    tests++; if (actq.size() != expq.size()) begin fails++; $display("FAIL single_nblk: got %0d want %0d", actq.size(), expq.size()); end
    for (int i = 0; i < actq.size() && i < expq.size(); i++) begin
      tests++; k = first_diff(actq[i].blk, expq[i].blk);
      if (actq[i].blk !== expq[i].blk || actq[i].last !== expq[i].last || actq[i].mode !== expq[i].mode) begin
        fails++; $display("FAIL single blk%0d: got last=%b mode=%0d lane%0d=%h want last=%b mode=%0d lane%0d=%h",
          i, actq[i].last, actq[i].mode, k, actq[i].blk[k%5][k/5], expq[i].last, expq[i].mode, k, expq[i].blk[k%5][k/5]);
      end
    end
    if (actq.size() > 0) begin
      tests++;
      if (actq[0].blk[0][0] !== 64'h0000_0000_0006_6261 || actq[0].blk[1][3] !== 64'h8000_0000_0000_0000) begin
        fails++; $display("FAIL single_const: lane00=%h lane13=%h want 0000000000066261 8000000000000000", actq[0].blk[0][0], actq[0].blk[1][3]);
      end
    end
  endtask

  task automatic test_exact_fill();
    int k;
    sel = 0; rdy_mode = 0; actq.delete(); expq.delete();
    send_msg(68, 1, -1, 0, 0, 1); model_msg(1); repeat (30) @(negedge clk);
    tests++; if (actq.size() != expq.size()) begin fails++; $display("FAIL exact_fill_nblk: got %0d want %0d", actq.size(), expq.size()); end
    for (int i = 0; i < actq.size() && i < expq.size(); i++) begin
      tests++; k = first_diff(actq[i].blk, expq[i].blk);
      if (actq[i].blk !== expq[i].blk || actq[i].last !== expq[i].last || actq[i].mode !== expq[i].mode) begin
        fails++; $display("FAIL exact_fill blk%0d: got last=%b mode=%0d lane%0d=%h want last=%b mode=%0d lane%0d=%h",
          i, actq[i].last, actq[i].mode, k, actq[i].blk[k%5][k/5], expq[i].last, expq[i].mode, k, expq[i].blk[k%5][k/5]);
      end
    end
  endtask

  task automatic test_merge();
    int k;
    sel = 1; rdy_mode = 0; actq.delete(); expq.delete();
    send_msg(135, 1, -1, 64'hAA, 0, 1); model_msg(1); repeat (20) @(negedge clk);
    send_msg(136, 1, -1, 64'hAA, 0, 1); model_msg(1); repeat (20) @(negedge clk);
    tests++; if (actq.size() != expq.size()) begin fails++; $display("FAIL merge_nblk: got %0d want %0d", actq.size(), expq.size()); end
    for (int i = 0; i < actq.size() && i < expq.size(); i++) begin
      tests++; k = first_diff(actq[i].blk, expq[i].blk);
      if (actq[i].blk !== expq[i].blk || actq[i].last !== expq[i].last || actq[i].mode !== expq[i].mode) begin
        fails++; $display("FAIL merge blk%0d: got last=%b mode=%0d lane%0d=%h want last=%b mode=%0d lane%0d=%h",
          i, actq[i].last, actq[i].mode, k, actq[i].blk[k%5][k/5], expq[i].last, expq[i].mode, k, expq[i].blk[k%5][k/5]);
      end
    end
    if (actq.size() > 0) begin
      tests++;
      if (actq[0].blk[1][3] !== 64'h86AA_AAAA_AAAA_AAAA) begin
        fails++; $display("FAIL merge_byte135: lane16 got %h want 86aaaaaaaaaaaaaa", actq[0].blk[1][3]);
      end
    end
    sel = 0;
  endtask

  task automatic test_stall();
    int k;
    sel = 0; rdy_mode = 2; actq.delete(); expq.delete();
    send_msg(37, 3, -1, -1, 0, 1); model_msg(3); repeat (40) @(negedge clk);
    tests++; if (actq.size() != 2) begin fails++; $display("FAIL stall_handshakes: got %0d want 2", actq.size()); end
    for (int i = 0; i < actq.size() && i < expq.size(); i++) begin
      tests++; k = first_diff(actq[i].blk, expq[i].blk);
      if (actq[i].blk !== expq[i].blk || actq[i].last !== expq[i].last || actq[i].mode !== expq[i].mode) begin
        fails++; $display("FAIL stall blk%0d: got last=%b mode=%0d lane%0d=%h want last=%b mode=%0d lane%0d=%h",
          i, actq[i].last, actq[i].mode, k, actq[i].blk[k%5][k/5], expq[i].last, expq[i].mode, k, expq[i].blk[k%5][k/5]);
      end
    end
    if (actq.size() > 0) begin
      tests++;
      if (actq[0].blk[4][1] !== 64'd0) begin fails++; $display("FAIL stall_lane9: got %h want 0", actq[0].blk[4][1]); end
    end
    rdy_mode = 0;
  endtask

  task automatic test_mode_latch();
    int k;
    sel = 0; rdy_mode = 0; actq.delete(); expq.delete();
    send_msg(80, 0, 3, -1, 0, 1); model_msg(0); repeat (30) @(negedge clk);
    tests++; if (actq.size() != expq.size()) begin fails++; $display("FAIL mode_latch_nblk: got %0d want %0d", actq.size(), expq.size()); end
    for (int i = 0; i < actq.size() && i < expq.size(); i++) begin
      tests++; k = first_diff(actq[i].blk, expq[i].blk);
      if (actq[i].blk !== expq[i].blk || actq[i].last !== expq[i].last || actq[i].mode !== expq[i].mode) begin
        fails++; $display("FAIL mode_latch blk%0d: got last=%b mode=%0d lane%0d=%h want last=%b mode=%0d lane%0d=%h",
          i, actq[i].last, actq[i].mode, k, actq[i].blk[k%5][k/5], expq[i].last, expq[i].mode, k, expq[i].blk[k%5][k/5]);
      end
    end
  endtask

  task automatic test_midreset();
    int k;
    sel = 0; rdy_mode = 0; actq.delete(); expq.delete();
    send_msg(10, 2, -1, -1, 0, 0);
    @(negedge clk); rst = 1; @(posedge clk); @(negedge clk);
    tests++; if (bv !== 0 || tready !== 0) begin fails++; $display("FAIL midreset_fill: valid=%b tready=%b want 0 0", bv, tready); end
    rst = 0;
    send_msg(1, 1, -1, -1, 0, 1); model_msg(1); repeat (20) @(negedge clk);
    tests++; if (actq.size() != expq.size()) begin fails++; $display("FAIL midreset_nblk: got %0d want %0d", actq.size(), expq.size()); end
    for (int i = 0; i < actq.size() && i < expq.size(); i++) begin
      tests++; k = first_diff(actq[i].blk, expq[i].blk);
      if (actq[i].blk !== expq[i].blk || actq[i].last !== expq[i].last || actq[i].mode !== expq[i].mode) begin
        fails++; $display("FAIL midreset blk%0d: got last=%b mode=%0d lane%0d=%h want last=%b mode=%0d lane%0d=%h",
          i, actq[i].last, actq[i].mode, k, actq[i].blk[k%5][k/5], expq[i].last, expq[i].mode, k, expq[i].blk[k%5][k/5]);
      end
    end
    // Reset while a full block is being offered and not taken.
    rdy_mode = 3;
    send_msg(36, 3, -1, -1, 0, 0);
    @(negedge clk);
    tests++; if (bv !== 1) begin fails++; $display("FAIL midreset_offer: valid got %b want 1", bv); end
    rst = 1; @(posedge clk); @(negedge clk);
    tests++; if (bv !== 0 || tready !== 0) begin fails++; $display("FAIL midreset_emit: valid=%b tready=%b want 0 0", bv, tready); end
    rst = 0; rdy_mode = 0; @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int k, mode;
    rdy_mode = 1; actq.delete(); expq.delete();
    for (int m = 0; m < 6; m++) begin
      @(negedge clk); sel = 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 3);
      send_msg($urandom_range(1, 150), mode, -1, -1, 1, 1); model_msg(mode);
      repeat (60) @(negedge clk);
    end
    tests++; if (actq.size() != expq.size()) begin fails++; $display("FAIL random_nblk: got %0d want %0d", actq.size(), expq.size()); end
    for (int i = 0; i < actq.size() && i < expq.size(); i++) begin
      tests++; k = first_diff(actq[i].blk, expq[i].blk);
      if (actq[i].blk !== expq[i].blk || actq[i].last !== expq[i].last || actq[i].mode !== expq[i].mode) begin
        fails++; $display("FAIL random blk%0d: got last=%b mode=%0d lane%0d=%h want last=%b mode=%0d lane%0d=%h",
          i, actq[i].last, actq[i].mode, k, actq[i].blk[k%5][k/5], expq[i].last, expq[i].mode, k, expq[i].blk[k%5][k/5]);
      end
    end
    rdy_mode = 0; sel = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_exact_fill();
    test_merge();
    test_stall();
    test_mode_latch();
    test_midreset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
